io_driver: RTL and testbench

IO_DRIVER -- requirements
Module: io_driver

---
 rtl/io_driver.sv | 105 ++++++++++
 tb/tb_io_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_driver.sv
// Single-pin output driver: accepts SET_LO / SET_HI / PULSE / TOGGLE
// commands and drives a registered pin level with rise/fall flags.
// A PULSE inverts the pin for max(len,1) cycles and then restores the
// level that was present before the pulse started.
module io_driver #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             en_i,
  output logic             y_o,
  output logic             oe_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy_o
);

  localparam logic [1:0] OpSetLo  = 2'b00;
  localparam logic [1:0] OpSetHi  = 2'b01;
  localparam logic [1:0] OpPulse  = 2'b10;
  localparam logic [1:0] OpToggle = 2'b11;

  typedef enum logic [0:0] {StIdle, StPulse} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               y_q, y_d;
  logic               pre_lvl_q, pre_lvl_d;
  logic               oe_q;
  logic               rise_q;
  logic               fall_q;
  logic               accept;

  // Ready only in IDLE and never while reset is held.
  assign cmd_ready_o = (state_q == StIdle) && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Next-state: command decode in IDLE, countdown and restore in PULSE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    pre_lvl_d = pre_lvl_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_op_i)
            OpSetLo:  y_d = 1'b0;
            OpSetHi:  y_d = 1'b1;
            OpToggle: y_d = ~y_q;
            OpPulse: begin
              y_d       = ~y_q;
              pre_lvl_d = y_q;
              // len 0 is treated as a one-cycle pulse.
              cnt_d     = (cmd_len_i == '0) ? '0 : cmd_len_i - LEN_W'(1);
              state_d   = StPulse;
            end
            default: y_d = y_q;
          endcase
        end
      end
      StPulse: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
        end else begin
          y_d     = pre_lvl_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset forces the pin low without a fall flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      y_q       <= 1'b0;
      pre_lvl_q <= 1'b0;
      oe_q      <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      pre_lvl_q <= pre_lvl_d;
      oe_q      <= en_i;
      rise_q    <= y_d & ~y_q;
      fall_q    <= ~y_d & y_q;
    end
  end

  assign y_o    = y_q;
  assign oe_o   = oe_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = (state_q == StPulse);

endmodule

// File: tb/tb_io_driver.sv
// Directed bench for io_driver; values are sampled 1 time unit after each
// rising edge. "Cycle N" means N edges after the command was presented.
module tb_io_driver;

  localparam int unsigned LEN_W = 16;
  localparam logic [1:0] SET_LO = 2'b00;
  localparam logic [1:0] SET_HI = 2'b01;
  localparam logic [1:0] PULSE  = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             en = 1'b0;
  logic             y, oe, rise, fall, busy;

  int n_checks = 0;
  int n_fail   = 0;

  io_driver #(.LEN_W(LEN_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_len_i  (cmd_len),
    .en_i       (en),
    .y_o        (y),
    .oe_o       (oe),
    .rise_o     (rise),
    .fall_o     (fall),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle, then drop valid.
  task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = SET_HI; en = 1'b1;
    step();
    step();
    n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL reset_y: got %b want 0", y); end
    n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", oe); end
    n_checks++; if (rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise: got %b want 0", rise); end
    n_checks++; if (fall !== 1'b0) begin n_fail++; $display("FAIL reset_fall: got %b want 0", fall); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    rst = 1'b0; cmd_valid = 1'b0; en = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_set_hi();
    issue(SET_HI, '0);
    n_checks++; if (y !== 1'b1) begin n_fail++; $display("FAIL set_hi_y: got %b want 1", y); end
    n_checks++; if (rise !== 1'b1) begin n_fail++; $display("FAIL set_hi_rise: got %b want 1", rise); end
    n_checks++; if (fall !== 1'b0) begin n_fail++; $display("FAIL set_hi_fall: got %b want 0", fall); end
    step();
    n_checks++; if (rise !== 1'b0) begin n_fail++; $display("FAIL set_hi_rise_c2: got %b want 0", rise); end
    n_checks++; if (y !== 1'b1) begin n_fail++; $display("FAIL set_hi_y_c2: got %b want 1", y); end
    issue(SET_HI, '0);
    n_checks++; if (y !== 1'b1) begin n_fail++; $display("FAIL set_hi_again_y: got %b want 1", y); end
    n_checks++; if (rise !== 1'b0) begin n_fail++; $display("FAIL set_hi_again_rise: got %b want 0", rise); end
    step();
    n_checks++; if (rise !== 1'b0) begin n_fail++; $display("FAIL set_hi_again_rise_c2: got %b want 0", rise); end
  endtask

  task automatic test_pulse3();
    logic ey, ebusy, erise, efall;
    issue(SET_LO, '0);
    step();
    cmd_valid = 1'b1; cmd_op = PULSE; cmd_len = LEN_W'(3);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      ey = (c <= 3); ebusy = (c <= 3); erise = (c == 1); efall = (c == 4);
      n_checks++; if (y !== ey) begin n_fail++; $display("FAIL pulse3_y c%0d: got %b want %b", c, y, ey); end
      n_checks++; if (busy !== ebusy) begin n_fail++; $display("FAIL pulse3_busy c%0d: got %b want %b", c, busy, ebusy); end
      n_checks++; if (cmd_ready !== !ebusy) begin n_fail++; $display("FAIL pulse3_ready c%0d: got %b want %b", c, cmd_ready, !ebusy); end
      n_checks++; if (rise !== erise) begin n_fail++; $display("FAIL pulse3_rise c%0d: got %b want %b", c, rise, erise); end
      n_checks++; if (fall !== efall) begin n_fail++; $display("FAIL pulse3_fall c%0d: got %b want %b", c, fall, efall); end
      step();
    end
  endtask

  task automatic test_pulse_short();
    for (int l = 0; l <= 1; l++) begin
      issue(PULSE, LEN_W'(l));
      n_checks++; if (y !== 1'b1) begin n_fail++; $display("FAIL pulse_len%0d_y c1: got %b want 1", l, y); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pulse_len%0d_busy c1: got %b want 1", l, busy); end
      n_checks++; if (rise !== 1'b1) begin n_fail++; $display("FAIL pulse_len%0d_rise c1: got %b want 1", l, rise); end
      step();
      n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL pulse_len%0d_y c2: got %b want 0", l, y); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pulse_len%0d_busy c2: got %b want 0", l, busy); end
      n_checks++; if (fall !== 1'b1) begin n_fail++; $display("FAIL pulse_len%0d_fall c2: got %b want 1", l, fall); end
      step();
    end
    issue(SET_HI, '0);
    issue(TOGGLE, '0);
    n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL toggle_y: got %b want 0", y); end
    n_checks++; if (fall !== 1'b1) begin n_fail++; $display("FAIL toggle_fall: got %b want 1", fall); end
    n_checks++; if (rise !== 1'b0) begin n_fail++; $display("FAIL toggle_rise: got %b want 0", rise); end
    step();
  endtask

  task automatic test_back_to_back();
    logic ey, erdy;
    logic [3:0] ey_b, erdy_b;
    // From y=0: SET_LO held through a len=5 pulse must not cut it short.
    cmd_valid = 1'b1; cmd_op = PULSE; cmd_len = LEN_W'(5);
    step();
    cmd_op = SET_LO;
    for (int c = 1; c <= 7; c++) begin
      ey = (c <= 5); erdy = (c >= 6);
      n_checks++; if (y !== ey) begin n_fail++; $display("FAIL b2b_a_y c%0d: got %b want %b", c, y, ey); end
      n_checks++; if (cmd_ready !== erdy) begin n_fail++; $display("FAIL b2b_a_ready c%0d: got %b want %b", c, cmd_ready, erdy); end
      if (c == 7) cmd_valid = 1'b0;
      step();
    end
    // From y=1: held SET_LO lands one edge after the restore.
    issue(SET_HI, '0);
    step();
    ey_b = 4'b0100; erdy_b = 4'b1100;
    cmd_valid = 1'b1; cmd_op = PULSE; cmd_len = LEN_W'(2);
    step();
    cmd_op = SET_LO;
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (y !== ey_b[c-1]) begin n_fail++; $display("FAIL b2b_b_y c%0d: got %b want %b", c, y, ey_b[c-1]); end
      n_checks++; if (cmd_ready !== erdy_b[c-1]) begin n_fail++; $display("FAIL b2b_b_ready c%0d: got %b want %b", c, cmd_ready, erdy_b[c-1]); end
      if (c == 4) cmd_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic ey, eoe;
    en = 1'b1;
    step();
    n_checks++; if (oe !== 1'b1) begin n_fail++; $display("FAIL oe_follow: got %b want 1", oe); end
    issue(PULSE, LEN_W'(8));
    en = 1'b0;
    step();
    n_checks++; if (y !== 1'b1) begin n_fail++; $display("FAIL rstp_y c2: got %b want 1", y); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstp_busy c2: got %b want 1", busy); end
    n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL rstp_oe c2: got %b want 0", oe); end
    rst = 1'b1;
    step();
    n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL rstp_y c3: got %b want 0", y); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstp_busy c3: got %b want 0", busy); end
    n_checks++; if (fall !== 1'b0) begin n_fail++; $display("FAIL rstp_fall c3: got %b want 0", fall); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_ready c3: got %b want 0", cmd_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_ready_release: got %b want 1", cmd_ready); end
    // en toggling during a len=3 pulse must leave the pulse shape alone.
    issue(PULSE, LEN_W'(3));
    for (int c = 1; c <= 4; c++) begin
      ey = (c <= 3);
      n_checks++; if (y !== ey) begin n_fail++; $display("FAIL en_pulse_y c%0d: got %b want %b", c, y, ey); end
      n_checks++; if (busy !== ey) begin n_fail++; $display("FAIL en_pulse_busy c%0d: got %b want %b", c, busy, ey); end
      if (c >= 2) begin
        eoe = ((c - 1) % 2) == 1;
        n_checks++; if (oe !== eoe) begin n_fail++; $display("FAIL en_pulse_oe c%0d: got %b want %b", c, oe, eoe); end
      end
      en = (c % 2) == 1;
      step();
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set_hi();
    test_pulse3();
    test_pulse_short();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
